lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the register file unit in the RISC-V datapath. Accepts one memory request per transaction (address from the ALU, store data from the register file's second read port), performs it against an internal word-organised data memory, and returns sign/zero-extended load data plus a write-back strobe into the register file. A three-state FSM gives fixed latency and a busy flag the pipeline uses to stall.

## Interface
Parameters:
- DEPTH, 256, data memory size in 32-bit words; power of two, at least 4.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe; sampled only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- store_data  input  32  store operand from the register file's second read port.
- rd_in  input  5  destination register for loads.
- busy  output  1  high while a request is in flight.
- done  output  1  one-cycle completion pulse.
- wb_en  output  1  register-file write strobe; high with done for successful loads only.
- rd_out  output  5  captured rd_in, valid with done.
- load_data  output  32  extended load result, valid with done.
- err  output  1  high with done when the request was misaligned or had an illegal funct3.

## Operation
- States: IDLE, ACCESS, RESP. IDLE -> ACCESS when req_valid=1; ACCESS -> RESP always; RESP -> IDLE always.
- In IDLE with req_valid=1, capture req_we, funct3, addr, store_data and rd_in. req_valid is ignored in ACCESS and RESP.
- Word index is addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Legality:
  - Loads accept 000, 001, 010, 100, 101. Stores accept 000, 001, 010. Every other code is illegal.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - An illegal request performs no memory write and returns err=1, wb_en=0, load_data=0.
- Stores (ACCESS edge):
  - SB writes store_data[7:0] to byte lane addr[1:0].
  - SH writes store_data[15:0] to half lane addr[1].
  - SW writes the whole word.
  - All other bytes of the word are unchanged.
- Loads (ACCESS edge):
  - Read the word, select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result into load_data for RESP.
- RESP:
  - done=1 and rd_out valid.
  - wb_en=1 only for a legal load.
  - Stores return load_data=0 and wb_en=0.
- Memory contents are not cleared by rst.

## Timing
- Reset values: state IDLE; busy, done, wb_en, err = 0; load_data = 0; rd_out = 0.
- Request sampled at edge T. busy=1 for cycles T+1 and T+2. done, wb_en, err, load_data and rd_out are valid during cycle T+2 only and return to 0 at the next edge.
- Throughput: one request per 3 cycles. A request presented in RESP is ignored. The requester holds req_valid until it sees busy=0.
- Store-then-load to the same address, back to back, returns the newly written value (write completes at the ACCESS edge of the store).
- rst has priority over every transition. rst asserted in ACCESS aborts the request: a pending store is not written, and the next cycle shows the reset values. rst asserted in RESP cancels the done pulse at the following edge.
- req_valid asserted together with rst is discarded.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> done with wb_en=1, load_data=0xDEADBEEF, rd_out=rd_in, err=0, exactly 2 cycles after each accept.
- After that store: LB from 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11 over word 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF. Then SH 0x1234 to 0x12 -> LW 0x10 returns 0x123455EF.
- LW from 0x11, SH to 0x13, and a load with funct3=011 -> err=1, wb_en=0, load_data=0. Word 0x10 is unchanged afterwards.
- Wrap-around, DEPTH=256: SW 0xA5A5A5A5 to 0x400, then LW from 0x000 -> 0xA5A5A5A5.
- Reset mid-operation: SW 0x11111111 to 0x20 with rst pulsed in ACCESS -> next cycle busy=0 and done=0; a later LW from 0x20 returns the prior contents. Also check: req_valid held high during busy is accepted only once per 3 cycles.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: a three-state request FSM wrapped around a word-organised data memory.
// Each request has a fixed latency: accept, then ACCESS, then a one-cycle RESP pulse.
module lsu #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [4:0]  rd_out,
  output logic [31:0] load_data,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state_reg;
  logic          we_reg;
  logic [2:0]    funct3_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   store_data_reg;
  logic [4:0]    rd_reg;
  logic          done_reg;
  logic          wb_en_reg;
  logic          err_reg;
  logic [4:0]    rd_out_reg;
  logic [31:0]   rd_word;

  // Address bits above the memory size wrap and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  logic          f3_ok;
  logic          misaligned;
  logic          legal;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic          wr_en;
  logic [AW-1:0] word_idx;

  assign word_idx = addr_reg[AW+1:2];

  always_comb begin
    f3_ok = 1'b0;
    case (funct3_reg)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !we_reg;
      default:                f3_ok = 1'b0;
    endcase
    misaligned = (funct3_reg[1:0] == 2'b01 && addr_reg[0]) ||
                 (funct3_reg[1:0] == 2'b10 && addr_reg[1:0] != 2'b00);
    legal = f3_ok && !misaligned;
  end

  // Narrow stores replicate the operand across lanes; byte_en picks the target lanes.
  always_comb begin
    byte_en = 4'b1111;
    wdata   = store_data_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_reg[1:0];
        wdata   = {4{store_data_reg[7:0]}};
      end
      2'b01: begin
        byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data_reg[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = store_data_reg;
      end
    endcase
  end

  assign wr_en = (state_reg == ACCESS) && !rst && we_reg && legal;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          mem[word_idx] <= wdata[gi*8 +: 8];
        end
        if (state_reg == ACCESS) begin
          rd_byte_reg <= mem[word_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      done_reg       <= 1'b0;
      wb_en_reg      <= 1'b0;
      err_reg        <= 1'b0;
      rd_out_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg         <= req_we;
            funct3_reg     <= funct3;
            addr_reg       <= addr[AW+1:0];
            store_data_reg <= store_data;
            rd_reg         <= rd_in;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          state_reg  <= RESP;
          done_reg   <= 1'b1;
          wb_en_reg  <= !we_reg && legal;
          err_reg    <= !legal;
          rd_out_reg <= rd_reg;
        end
        RESP: begin
          state_reg  <= IDLE;
          done_reg   <= 1'b0;
          wb_en_reg  <= 1'b0;
          err_reg    <= 1'b0;
          rd_out_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Lane select and extension act on the registered word; request fields stay stable through RESP.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  always_comb begin
    case (addr_reg[1:0])
      2'b00:   sel_byte = rd_word[7:0];
      2'b01:   sel_byte = rd_word[15:8];
      2'b10:   sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_reg)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  ext_data = rd_word;
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = '0;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign wb_en     = wb_en_reg;
  assign err       = err_reg;
  assign rd_out    = rd_out_reg;
  assign load_data = wb_en_reg ? ext_data : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: fixed-latency load/store transactions with hand-computed results.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [4:0]  rd_out;
  logic [31:0] load_data;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .wb_en      (wb_en),
    .rd_out     (rd_out),
    .load_data  (load_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic txn(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                     input logic [31:0] exp_data, input logic exp_wb, input logic exp_err);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd_in      = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({name, ".busy_t1"}, busy, 32'd1);
    check({name, ".done_t1"}, done, 32'd0);
    @(posedge clk);
    #1;
    check({name, ".busy_t2"}, busy, 32'd1);
    check({name, ".done_t2"}, done, 32'd1);
    check({name, ".wb_en"}, wb_en, exp_wb);
    check({name, ".err"}, err, exp_err);
    check({name, ".load_data"}, load_data, exp_data);
    check({name, ".rd_out"}, rd_out, rd);
    $display("[TB] %s we=%0d f3=%03b addr=0x%08h sd=0x%08h -> data=0x%08h wb_en=%0d err=%0d rd=%0d",
             name, we, f3, a, sd, load_data, wb_en, err, rd_out);
    @(posedge clk);
    #1;
    check({name, ".busy_t3"}, busy, 32'd0);
    check({name, ".done_t3"}, done, 32'd0);
    check({name, ".wb_en_t3"}, wb_en, 32'd0);
    check({name, ".data_t3"}, load_data, 32'd0);
  endtask

  logic [6:0] busy_hist;
  logic [6:0] done_hist;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    store_data = '0;
    rd_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 32'd0);
    check("reset.done", done, 32'd0);
    check("reset.wb_en", wb_en, 32'd0);
    check("reset.err", err, 32'd0);
    check("reset.load_data", load_data, 32'd0);
    check("reset.rd_out", rd_out, 32'd0);
    $display("[TB] reset state checked");
    @(negedge clk);
    rst = 1'b0;

    txn("sw_10",    1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 1'b0);
    txn("lw_10",    1'b0, 3'b010, 32'h10, 32'h0,        5'd5,  32'hDEADBEEF, 1'b1, 1'b0);
    txn("lb_13",    1'b0, 3'b000, 32'h13, 32'h0,        5'd6,  32'hFFFFFFDE, 1'b1, 1'b0);
    txn("lbu_13",   1'b0, 3'b100, 32'h13, 32'h0,        5'd7,  32'h000000DE, 1'b1, 1'b0);
    txn("lh_12",    1'b0, 3'b001, 32'h12, 32'h0,        5'd8,  32'hFFFFDEAD, 1'b1, 1'b0);
    txn("lhu_10",   1'b0, 3'b101, 32'h10, 32'h0,        5'd9,  32'h0000BEEF, 1'b1, 1'b0);
    txn("sb_11",    1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 5'd2,  32'h0,        1'b0, 1'b0);
    txn("lw_sb",    1'b0, 3'b010, 32'h10, 32'h0,        5'd10, 32'hDEAD55EF, 1'b1, 1'b0);
    txn("sh_12",    1'b1, 3'b001, 32'h12, 32'hBBBB1234, 5'd3,  32'h0,        1'b0, 1'b0);
    txn("lw_sh",    1'b0, 3'b010, 32'h10, 32'h0,        5'd11, 32'h123455EF, 1'b1, 1'b0);
    txn("lw_mis",   1'b0, 3'b010, 32'h11, 32'h0,        5'd12, 32'h0,        1'b0, 1'b1);
    txn("sh_mis",   1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 5'd13, 32'h0,        1'b0, 1'b1);
    txn("ld_f3_011",1'b0, 3'b011, 32'h10, 32'h0,        5'd14, 32'h0,        1'b0, 1'b1);
    txn("sbu_ill",  1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 5'd15, 32'h0,        1'b0, 1'b1);
    txn("lw_unchg", 1'b0, 3'b010, 32'h10, 32'h0,        5'd16, 32'h123455EF, 1'b1, 1'b0);
    txn("sw_400",   1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 5'd17, 32'h0,       1'b0, 1'b0);
    txn("lw_000",   1'b0, 3'b010, 32'h0,  32'h0,        5'd18, 32'hA5A5A5A5, 1'b1, 1'b0);
    txn("sw_20",    1'b1, 3'b010, 32'h20, 32'h0BADF00D, 5'd19, 32'h0,        1'b0, 1'b0);

    // Store aborted by reset during ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 32'h20; store_data = 32'h11111111; rd_in = 5'd20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort.busy_t1", busy, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.busy", busy, 32'd0);
    check("abort.done", done, 32'd0);
    check("abort.err", err, 32'd0);
    check("abort.rd_out", rd_out, 32'd0);
    $display("[TB] abort store 0x20 by reset in ACCESS: busy=%0d done=%0d", busy, done);
    @(negedge clk);
    rst = 1'b0;
    txn("lw_20",    1'b0, 3'b010, 32'h20, 32'h0,        5'd21, 32'h0BADF00D, 1'b1, 1'b0);

    // Reset during RESP cancels the done pulse.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10; rd_in = 5'd22;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("resp_rst.done_t2", done, 32'd1);
    check("resp_rst.data_t2", load_data, 32'h123455EF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("resp_rst.done", done, 32'd0);
    check("resp_rst.busy", busy, 32'd0);
    check("resp_rst.wb_en", wb_en, 32'd0);
    check("resp_rst.load_data", load_data, 32'd0);
    $display("[TB] reset in RESP: done=%0d busy=%0d", done, busy);

    // Request presented together with reset is discarded.
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req.busy", busy, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req.busy_after", busy, 32'd0);
    $display("[TB] req_valid with rst discarded: busy=%0d", busy);

    // req_valid held high: one accept per three cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10; rd_in = 5'd7;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      busy_hist[i] = busy;
      done_hist[i] = done;
      if (i == 3) req_valid = 1'b0;
    end
    check("held.busy_hist", {25'd0, busy_hist}, 32'b0011011);
    check("held.done_hist", {25'd0, done_hist}, 32'b0010010);
    $display("[TB] held req_valid: busy_hist=%07b done_hist=%07b", busy_hist, done_hist);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
